// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands in a small FIFO, issues them one at a time
// to a registered ALU and returns each result over a valid/ready handshake.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [3:0]       cmd_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [7:0]       alu_out,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic             res_carry,
    output logic             res_err,
    output logic [PTR_W:0]   fifo_count,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESULT} state_t;

    state_t             r_state;
    logic [19:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [7:0]         r_alu_a, r_alu_b, r_res_data;
    logic [3:0]         r_alu_sel;
    logic               r_err_pend, r_res_err, r_res_carry, r_res_valid;
    logic               w_push, w_pop, w_head_err;
    logic [19:0]        w_head;

    assign cmd_ready  = r_count < (PTR_W+1)'(DEPTH);
    assign w_push     = cmd_valid && cmd_ready;
    assign w_pop      = (r_count != 0) && ((r_state == IDLE) || (r_state == RESULT && res_ready));
    assign w_head     = r_mem[r_rd_ptr];
    // error comes from the command itself, never from the ALU result value
    assign w_head_err = (w_head[19:16] > 4'd3) || (w_head[19:16] == 4'd3 && w_head[15:8] == 8'd0);

    always_ff @(posedge clock)
        if (w_push) r_mem[r_wr_ptr] <= {cmd_op, cmd_b, cmd_a};

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            r_state     <= IDLE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_err_pend  <= 1'b0;
            r_res_data  <= '0;
            r_res_carry <= 1'b0;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_alu_a    <= w_head[7:0];
                r_alu_b    <= w_head[15:8];
                r_alu_sel  <= w_head[19:16];
                r_err_pend <= w_head_err;
            end
            case (r_state)
                IDLE:    r_state <= w_pop ? ISSUE : IDLE;
                ISSUE:   r_state <= CAPTURE;
                CAPTURE: begin
                    r_res_data  <= alu_out;
                    r_res_carry <= alu_carry;
                    r_res_err   <= r_err_pend;
                    r_res_valid <= 1'b1;
                    r_state     <= RESULT;
                end
                RESULT: if (res_ready) begin
                    r_res_valid <= 1'b0;
                    r_state     <= w_pop ? ISSUE : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_carry  = r_res_carry;
    assign res_err    = r_res_err;
    assign fifo_count = r_count;
    assign busy       = (r_state != IDLE) || (r_count != 0);
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed and random checks of alu_cmd_sequencer against
// an expected-result queue, with a registered ALU stand-in driving alu_out/alu_carry.
module tb_alu_cmd_sequencer;
    logic       clock = 0, reset = 1;
    logic       cmd_valid = 0, cmd_ready, res_ready = 0;
    logic [7:0] cmd_a = 0, cmd_b = 0;
    logic [3:0] cmd_op = 0;
    logic [7:0] alu_a, alu_b, alu_out, res_data;
    logic [3:0] alu_sel;
    logic       alu_carry, res_valid, res_carry, res_err, busy;
    logic [2:0] fifo_count;

    int n_tests = 0, n_fail = 0, n_xfer = 0, cyc = 0;
    logic [9:0] exp_q[$];
    int xfer_cyc[$];
    logic       held = 0;
    logic [9:0] prev = 0;

    alu_cmd_sequencer #(.DEPTH(4), .PTR_W(2)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_carry(res_carry), .res_err(res_err),
        .fifo_count(fifo_count), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // {carry, data} the ALU produces for an operation
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            4'd0: return 9'(a) + 9'(b);
            4'd1: return {1'b0, 8'(a - b)};
            4'd2: return {1'b0, p[7:0]};
            4'd3: return (b == 0) ? 9'h0AC : {1'b0, 8'(a / b)};
            default: return 9'h0AC;
        endcase
    endfunction

    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        return {(op > 3) || (op == 3 && b == 0), alu_fn(a, b, op)};
    endfunction

    always_ff @(posedge clock or posedge reset)
        if (reset) {alu_carry, alu_out} <= '0;
        else {alu_carry, alu_out} <= alu_fn(alu_a, alu_b, alu_sel);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mid-cycle monitor: inputs and outputs are settled, the edge has not happened yet
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            held = 0;
        end else begin
            if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_a, cmd_b, cmd_op));
            if (held) check("res_hold", {res_err, res_carry, res_data}, prev[9:0]);
            if (res_valid && res_ready) begin
                check("xfer_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("res_out", {res_err, res_carry, res_data}, exp_q.pop_front());
                end
                n_xfer++;
                xfer_cyc.push_back(cyc);
            end
            held = res_valid && !res_ready;
            prev = {res_err, res_carry, res_data};
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int k = 0;
        cmd_valid = 1; cmd_a = a; cmd_b = b; cmd_op = op;
        while (!cmd_ready && k < 50) begin step(); k++; end
        step();
        cmd_valid = 0;
        if (k >= 50) check("push_timeout", k, 0);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!res_valid && k < 50) begin step(); k++; end
        check("valid_timeout", 32'(k < 50), 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        res_ready = 1;
        while ((busy || res_valid) && k < 200) begin step(); k++; end
        check("drain_timeout", 32'(k < 200), 1);
    endtask

    initial begin
        int acc, n0;
        repeat (3) step();
        reset = 0;
        step();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_count", fifo_count, 0);
        check("rst_outputs", {res_valid, res_data, res_carry, res_err, alu_a, alu_b, alu_sel, busy}, 0);

        // latency and first result
        push(200, 100, 0);
        step();
        check("issue_sel", alu_sel, 0);
        check("issue_a", alu_a, 200);
        check("issue_valid", res_valid, 0);
        step();
        check("capture_valid", res_valid, 0);
        step();
        check("lat_valid", res_valid, 1);
        check("lat_result", {res_err, res_carry, res_data}, {1'b0, 1'b1, 8'h2C});
        res_ready = 1;
        step();
        check("after_xfer_valid", res_valid, 0);
        wait_idle();

        // back-to-back throughput
        xfer_cyc.delete();
        push(5, 10, 1);
        push(16, 17, 2);
        push(100, 7, 3);
        wait_idle();
        check("tp_count", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3) begin
            check("tp_gap1", xfer_cyc[1] - xfer_cyc[0], 3);
            check("tp_gap2", xfer_cyc[2] - xfer_cyc[1], 3);
        end

        // error flag is independent of the 0xAC result value
        push(50, 0, 3);
        push(9, 9, 7);
        push(8'h56, 8'h56, 0);
        wait_idle();

        // fill with the consumer stalled
        res_ready = 0;
        n0 = n_xfer;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_valid = 1; cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 4'($urandom_range(0, 5));
            if (cmd_ready) acc++;
            step();
        end
        cmd_valid = 0;
        check("fill_accepted", acc, 5);
        check("fill_ready", cmd_ready, 0);
        check("fill_count", fifo_count, 4);
        check("fill_valid", res_valid, 1);
        res_ready = 1;
        step();
        check("first_pop_ready", cmd_ready, 1);
        check("first_pop_count", fifo_count, 3);
        wait_idle();
        check("fill_xfers", n_xfer - n0, 5);

        // hold, then a single-cycle ready pulse
        res_ready = 0;
        push(77, 3, 2);
        push(1, 2, 1);
        wait_valid();
        n0 = n_xfer;
        for (int i = 0; i < 10; i++) step();
        check("hold_valid", res_valid, 1);
        res_ready = 1;
        step();
        res_ready = 0;
        check("pulse_xfer", n_xfer - n0, 1);
        check("pulse_valid", res_valid, 0);
        repeat (5) step();
        check("pulse_once", n_xfer - n0, 1);
        check("second_valid", res_valid, 1);
        wait_idle();

        // reset while capturing with three queued
        res_ready = 0;
        for (int i = 0; i < 5; i++) push(8'(i + 1), 8'(i + 2), 4'(i % 4));
        wait_valid();
        check("pre_rst_count", fifo_count, 4);
        res_ready = 1;
        step();
        res_ready = 0;
        step();
        check("capture_count", fifo_count, 3);
        check("capture_nvalid", res_valid, 0);
        reset = 1;
        #1;
        check("mid_rst_outputs", {res_valid, res_data, res_carry, res_err, alu_a, alu_b, alu_sel, busy}, 0);
        check("mid_rst_count", fifo_count, 0);
        repeat (2) step();
        reset = 0;
        step();
        check("post_rst_ready", cmd_ready, 1);
        n0 = n_xfer;
        res_ready = 1;
        repeat (10) step();
        check("no_stale_valid", res_valid, 0);
        check("no_stale_xfer", n_xfer - n0, 0);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            cmd_valid = 1'($urandom);
            cmd_a = 8'($urandom);
            cmd_b = ($urandom % 4 == 0) ? 8'd0 : 8'($urandom);
            cmd_op = 4'($urandom_range(0, 5));
            res_ready = 1'($urandom);
            step();
        end
        cmd_valid = 0;
        wait_idle();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_count", fifo_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
